// File: rtl/heart_rate_meter.sv
// Heartbeat front-end: debounces the raw pulse, counts beats per sub-window and
// reports the sliding sum of the last four sub-windows as beats per minute.
module heart_rate_meter #(
    parameter int TICK_DIV      = 50000,
    parameter int SUBWIN_TICKS  = 15000,
    parameter int REFRACT_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hartPuls,
    output logic [7:0] hartRitme,
    output logic       ritmeGeldig,
    output logic       nieuweWaarde,
    output logic       geenPuls
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
    localparam int TW = (SUBWIN_TICKS > 1) ? $clog2(SUBWIN_TICKS + 1) : 1;
    localparam int RW = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

    typedef enum logic {ST_WARMUP, ST_RUN} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_255(input logic [9:0] s);
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

    logic          r_sync1, r_sync2, r_sync3;
    logic [PW-1:0] r_presc;
    logic [RW-1:0] r_refract;
    logic [TW-1:0] r_tickcnt;
    logic [7:0]    r_beats;
    logic [7:0]    r_h0, r_h1, r_h2, r_h3;
    logic [2:0]    r_fill;
    logic          r_close_d;
    logic [7:0]    r_ritme;
    logic          r_nieuw;
    logic          r_geen;
    state_t        r_state;
    state_t        w_state_nxt;

    logic       w_edge;
    logic       w_tick;
    logic       w_accept;
    logic       w_close;
    logic       w_update;
    logic       w_geldig;
    logic [9:0] w_sum;

    assign w_edge   = r_sync2 & ~r_sync3;
    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
    assign w_accept = w_edge && (r_refract == '0);
    assign w_close  = w_tick && (r_tickcnt == TW'(SUBWIN_TICKS - 1));
    assign w_sum    = {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2} + {2'b00, r_h3};

    // Synchroniser, 1 ms prescaler and refractory lockout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_presc   <= '0;
            r_refract <= '0;
        end else begin
            r_sync1 <= hartPuls;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_accept)
                r_refract <= RW'(REFRACT_TICKS);
            else if (w_tick && (r_refract != '0))
                r_refract <= r_refract - 1'b1;
        end
    end

    // Sub-window counting; a beat accepted on the closure cycle belongs to the closing window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tickcnt <= '0;
            r_beats   <= 8'd0;
            r_h0      <= 8'd0;
            r_h1      <= 8'd0;
            r_h2      <= 8'd0;
            r_h3      <= 8'd0;
            r_fill    <= 3'd0;
            r_close_d <= 1'b0;
        end else begin
            r_close_d <= w_close;
            if (w_tick)
                r_tickcnt <= w_close ? '0 : r_tickcnt + 1'b1;
            if (w_close) begin
                r_h3    <= r_h2;
                r_h2    <= r_h1;
                r_h1    <= r_h0;
                r_h0    <= w_accept ? sat_inc8(r_beats) : r_beats;
                r_beats <= 8'd0;
                if (r_fill != 3'd4)
                    r_fill <= r_fill + 3'd1;
            end else if (w_accept) begin
                r_beats <= sat_inc8(r_beats);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_WARMUP;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_WARMUP) && w_update)
            w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_update = r_close_d && (r_fill == 3'd4);
        w_geldig = (r_state == ST_RUN);
    end

    // Post-closure output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ritme <= 8'd0;
            r_nieuw <= 1'b0;
            r_geen  <= 1'b0;
        end else begin
            r_nieuw <= w_update;
            if (w_update)
                r_ritme <= sat_255(w_sum);
            if (r_close_d && (r_fill >= 3'd2)) begin
                if ((r_h0 == 8'd0) && (r_h1 == 8'd0))
                    r_geen <= 1'b1;
                else if (r_h0 != 8'd0)
                    r_geen <= 1'b0;
            end
        end
    end

    assign hartRitme    = r_ritme;
    assign ritmeGeldig  = w_geldig;
    assign nieuweWaarde = r_nieuw;
    assign geenPuls     = r_geen;

endmodule

// File: tb/tb_heart_rate_meter.sv
// Directed bench for heart_rate_meter: small-parameter instance for timing and
// history behaviour, plus a fast-tick instance for sum saturation.
module tb_heart_rate_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       hartPuls;
    logic       hartPuls_s;
    logic [7:0] hartRitme, hartRitme_s;
    logic       ritmeGeldig, ritmeGeldig_s;
    logic       nieuweWaarde, nieuweWaarde_s;
    logic       geenPuls, geenPuls_s;

    int passed = 0;
    int total  = 0;
    int e      = 0;
    bit sat_on = 1'b0;
    int drv_q[$];

    typedef struct {
        int         at;
        bit         on;
        logic [7:0] ritme;
        logic       geldig;
        logic       nieuw;
        logic       geen;
    } vec_t;

    vec_t tv[12];

    always #5 clk = ~clk;

    heart_rate_meter #(.TICK_DIV(4), .SUBWIN_TICKS(10), .REFRACT_TICKS(2)) dut (
        .clk(clk), .reset(reset), .hartPuls(hartPuls),
        .hartRitme(hartRitme), .ritmeGeldig(ritmeGeldig),
        .nieuweWaarde(nieuweWaarde), .geenPuls(geenPuls)
    );

    heart_rate_meter #(.TICK_DIV(1), .SUBWIN_TICKS(200), .REFRACT_TICKS(1)) dut_s (
        .clk(clk), .reset(reset), .hartPuls(hartPuls_s),
        .hartRitme(hartRitme_s), .ritmeGeldig(ritmeGeldig_s),
        .nieuweWaarde(nieuweWaarde_s), .geenPuls(geenPuls_s)
    );

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            passed++;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic g,
                           input logic n, input logic p);
        chk({tag, " hartRitme"},    {2'b00, hartRitme},    {2'b00, r});
        chk({tag, " ritmeGeldig"},  {9'd0, ritmeGeldig},   {9'd0, g});
        chk({tag, " nieuweWaarde"}, {9'd0, nieuweWaarde},  {9'd0, n});
        chk({tag, " geenPuls"},     {9'd0, geenPuls},      {9'd0, p});
    endtask

    function automatic bit in_drv(input int v);
        foreach (drv_q[i])
            if (drv_q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Edge e is the e-th rising clock after reset release; inputs change 1 unit after it
    task automatic adv(input int target, input bit periodic);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
            hartPuls   = (periodic && (e % 20 == 5)) || in_drv(e);
            hartPuls_s = sat_on ? ~hartPuls_s : 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        hartPuls   = 1'b0;
        hartPuls_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e     = 0;
        drv_q.delete();
    endtask

    initial begin
        tv[0]  = '{40,  1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{41,  1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{160, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{161, 1'b1, 8'd8, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{162, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{200, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{201, 1'b0, 8'd8, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{241, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0};
        tv[8]  = '{242, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{281, 1'b0, 8'd4, 1'b1, 1'b1, 1'b1};
        tv[10] = '{300, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1};
        tv[11] = '{321, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0};

        reset      = 1'b1;
        hartPuls   = 1'b0;
        hartPuls_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("in_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        e     = 0;

        // Idle after reset: loss flag after the second closure, zero rate after the fourth
        adv(41, 1'b0);  chk_out("idle41", 8'd0, 1'b0, 1'b0, 1'b0);
        adv(80, 1'b0);  chk_out("idle80", 8'd0, 1'b0, 1'b0, 1'b0);
        adv(81, 1'b0);  chk_out("idle81", 8'd0, 1'b0, 1'b0, 1'b1);
        adv(160, 1'b0); chk_out("idle160", 8'd0, 1'b0, 1'b0, 1'b1);
        adv(161, 1'b0); chk_out("idle161", 8'd0, 1'b1, 1'b1, 1'b1);

        // Steady 2 beats/window, then two empty windows, then recovery
        do_reset();
        for (int i = 0; i < 12; i++) begin
            adv(tv[i].at, tv[i].on);
            chk_out($sformatf("vec%0d@%0d", i, tv[i].at), tv[i].ritme, tv[i].geldig,
                    tv[i].nieuw, tv[i].geen);
        end

        // Asynchronous reset mid-cycle clears everything without a clock edge
        #3;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("async_rst_hold", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        e     = 0;
        drv_q.delete();

        // Refractory: pulses 2 clks apart count once, 12 clks apart count twice
        drv_q = '{5, 7, 45, 57};
        adv(81, 1'b0);  chk_out("refr81", 8'd0, 1'b0, 1'b0, 1'b0);
        adv(121, 1'b0); chk_out("refr121", 8'd0, 1'b0, 1'b0, 1'b0);
        adv(161, 1'b0); chk_out("refr161", 8'd3, 1'b1, 1'b1, 1'b1);

        // Beat accepted exactly on the closure edge belongs to the closing window
        do_reset();
        drv_q = '{37};
        adv(81, 1'b0);  chk_out("close81", 8'd0, 1'b0, 1'b0, 1'b0);
        adv(121, 1'b0); chk_out("close121", 8'd0, 1'b0, 1'b0, 1'b1);
        adv(161, 1'b0); chk_out("close161", 8'd1, 1'b1, 1'b1, 1'b1);

        // Saturation: ~100 beats per window on the fast instance, sum clamps at 255
        do_reset();
        sat_on = 1'b1;
        adv(800, 1'b0);
        chk("sat800 ritmeGeldig", {9'd0, ritmeGeldig_s}, 10'd0);
        adv(801, 1'b0);
        chk("sat801 hartRitme",    {2'b00, hartRitme_s},  10'd255);
        chk("sat801 nieuweWaarde", {9'd0, nieuweWaarde_s}, 10'd1);
        chk("sat801 ritmeGeldig",  {9'd0, ritmeGeldig_s},  10'd1);
        sat_on = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
